// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - decode-stage hazard scoreboard with per-register latency countdown
module pipeline_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int LAT_W    = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   rs_D,
  input  logic [ADDR_W-1:0]   rt_D,
  input  logic                re1_D,
  input  logic                re2_D,
  input  logic                we_D,
  input  logic [ADDR_W-1:0]   wd_D,
  input  logic [LAT_W-1:0]    lat_D,
  input  logic                freeze,
  input  logic                flush_D,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    stall_cycles
);

  // Register 0 is never tracked, so the counter array starts at 1.
  logic [LAT_W-1:0] cnt [1:NUM_REGS-1];
  logic             rs_pending;
  logic             rt_pending;
  logic             hz_rs;
  logic             hz_rt;
  logic             accept;

  // Compare-based lookup keeps out-of-range specifiers from indexing the array.
  always_comb begin
    rs_pending = 1'b0;
    rt_pending = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs_D == ADDR_W'(i) && cnt[i] != '0) rs_pending = 1'b1;
      if (rt_D == ADDR_W'(i) && cnt[i] != '0) rt_pending = 1'b1;
    end
  end

  assign hz_rs  = re1_D & rs_pending;
  assign hz_rt  = re2_D & rt_pending;
  assign stall  = issue_valid & ~flush_D & (hz_rs | hz_rt);
  assign accept = issue_valid & ~stall & ~flush_D & ~freeze;

  assign busy[0] = 1'b0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_busy
    assign busy[g] = |cnt[g];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) cnt[i] <= '0;
      stall_cycles <= '0;
    end else if (!freeze) begin
      // A fresh producer overrides any older pending latency (youngest writer wins).
      for (int i = 1; i < NUM_REGS; i++) begin
        if (accept && we_D && wd_D == ADDR_W'(i)) begin
          cnt[i] <= lat_D;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
      if (stall && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb/tb_pipeline_scoreboard.sv - directed table plus randomized model-checked bench for pipeline_scoreboard
module tb_pipeline_scoreboard;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int LW = 3;
  localparam int CW = 6;
  localparam int SC_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, issue_valid, re1_D, re2_D, we_D, freeze, flush_D;
  logic [AW-1:0] rs_D, rt_D, wd_D;
  logic [LW-1:0] lat_D;
  logic          stall;
  logic [NR-1:0] busy;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .LAT_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .rs_D(rs_D), .rt_D(rt_D), .re1_D(re1_D), .re2_D(re2_D),
    .we_D(we_D), .wd_D(wd_D), .lat_D(lat_D),
    .freeze(freeze), .flush_D(flush_D),
    .stall(stall), .busy(busy), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic          rst;
    logic          iv;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          r1;
    logic          r2;
    logic          we;
    logic [AW-1:0] wd;
    logic [LW-1:0] lat;
    logic          frz;
    logic          fl;
    logic          e_stall;
    logic [NR-1:0] e_busy;
    int            e_sc;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  // Reference model: a register is pending until the count of unfrozen edges reaches its ready time.
  int ready_at [NR];
  int active;
  int msc;

  function automatic vec_t v(logic rst, logic iv, int rs, int rt, logic r1, logic r2, logic we,
                             int wd, int lat, logic frz, logic fl, logic es, logic [NR-1:0] eb, int esc);
    vec_t t;
    t.rst = rst; t.iv = iv; t.rs = AW'(rs); t.rt = AW'(rt); t.r1 = r1; t.r2 = r2;
    t.we = we; t.wd = AW'(wd); t.lat = LW'(lat); t.frz = frz; t.fl = fl;
    t.e_stall = es; t.e_busy = eb; t.e_sc = esc;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    rst_n = t.rst; issue_valid = t.iv; rs_D = t.rs; rt_D = t.rt; re1_D = t.r1; re2_D = t.r2;
    we_D = t.we; wd_D = t.wd; lat_D = t.lat; freeze = t.frz; flush_D = t.fl;
  endtask

  task automatic check(input string name, input int idx, input logic [NR-1:0] act, input logic [NR-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic m_busy(input logic [AW-1:0] r);
    return (r != 0) && (ready_at[r] > active);
  endfunction

  initial begin
    logic          m_stall;
    logic [NR-1:0] m_busy_vec;
    logic          model_valid;

    //                rst iv rs rt r1 r2 we wd lat frz fl   stall busy          sc
    tbl[0]  = v(1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 32'h0,        0);
    tbl[1]  = v(1, 1,  0, 0, 0, 0, 1,  8, 1, 0, 0,  0, 32'h0,        0);
    tbl[2]  = v(1, 1,  8, 0, 1, 0, 0,  0, 0, 0, 0,  1, 32'h100,      0);
    tbl[3]  = v(1, 1,  8, 0, 1, 0, 0,  0, 0, 0, 0,  0, 32'h0,        1);
    tbl[4]  = v(1, 1,  0, 0, 0, 0, 1,  9, 3, 0, 0,  0, 32'h0,        1);
    tbl[5]  = v(1, 1,  0, 9, 0, 1, 0,  0, 0, 0, 0,  1, 32'h200,      1);
    tbl[6]  = v(1, 1,  0, 9, 0, 1, 0,  0, 0, 0, 0,  1, 32'h200,      2);
    tbl[7]  = v(1, 1,  0, 9, 0, 1, 0,  0, 0, 0, 0,  1, 32'h200,      3);
    tbl[8]  = v(1, 1,  0, 9, 0, 1, 0,  0, 0, 0, 0,  0, 32'h0,        4);
    tbl[9]  = v(1, 1,  0, 0, 0, 0, 1,  9, 3, 0, 0,  0, 32'h0,        4);
    tbl[10] = v(1, 1,  0, 9, 0, 0, 0,  0, 0, 0, 0,  0, 32'h200,      4);
    tbl[11] = v(1, 1,  0, 0, 0, 0, 1, 10, 3, 0, 0,  0, 32'h200,      4);
    tbl[12] = v(1, 1, 10, 0, 1, 0, 0,  0, 0, 0, 0,  1, 32'h600,      4);
    tbl[13] = v(1, 1, 10, 0, 1, 0, 0,  0, 0, 1, 0,  1, 32'h400,      5);
    tbl[14] = v(1, 1, 10, 0, 1, 0, 0,  0, 0, 1, 0,  1, 32'h400,      5);
    tbl[15] = v(1, 1, 10, 0, 1, 0, 0,  0, 0, 0, 0,  1, 32'h400,      5);
    tbl[16] = v(1, 1, 10, 0, 1, 0, 0,  0, 0, 0, 0,  1, 32'h400,      6);
    tbl[17] = v(1, 1, 10, 0, 1, 0, 0,  0, 0, 0, 0,  0, 32'h0,        7);
    tbl[18] = v(1, 1,  0, 0, 0, 0, 1, 11, 4, 0, 0,  0, 32'h0,        7);
    tbl[19] = v(1, 1,  0, 0, 0, 0, 1, 11, 0, 0, 0,  0, 32'h800,      7);
    tbl[20] = v(1, 1, 11, 0, 1, 0, 0,  0, 0, 0, 0,  0, 32'h0,        7);
    tbl[21] = v(1, 1,  0, 0, 0, 0, 1,  0, 7, 0, 0,  0, 32'h0,        7);
    tbl[22] = v(1, 1,  0, 0, 1, 1, 0,  0, 0, 0, 0,  0, 32'h0,        7);
    tbl[23] = v(1, 1,  0, 0, 0, 0, 1, 12, 2, 0, 1,  0, 32'h0,        7);
    tbl[24] = v(1, 1, 12, 0, 1, 0, 0,  0, 0, 0, 0,  0, 32'h0,        7);
    tbl[25] = v(1, 1,  0, 0, 0, 0, 1, 13, 5, 0, 0,  0, 32'h0,        7);
    tbl[26] = v(0, 1, 13, 0, 1, 0, 0,  0, 0, 1, 0,  1, 32'h2000,     7);
    tbl[27] = v(1, 1, 13, 0, 1, 0, 0,  0, 0, 0, 0,  0, 32'h0,        0);

    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0));
    repeat (2) @(posedge clk);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      apply(tbl[k]);
      #1;
      check("dir_stall", k, NR'(stall), NR'(tbl[k].e_stall));
      check("dir_busy", k, busy, tbl[k].e_busy);
      check("dir_stall_cycles", k, NR'(stall_cycles), NR'(tbl[k].e_sc));
    end

    // Randomized phase; the first cycle forces reset so the model starts in step with the DUT.
    model_valid = 1'b0;
    active = 0;
    msc = 0;
    for (int r = 0; r < NR; r++) ready_at[r] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst_n       = (c == 0) ? 1'b0 : ($urandom_range(0, 499) != 0);
      issue_valid = ($urandom_range(0, 3) != 0);
      rs_D        = AW'($urandom_range(0, 7));
      rt_D        = AW'($urandom_range(0, 7));
      re1_D       = 1'($urandom_range(0, 1));
      re2_D       = 1'($urandom_range(0, 1));
      we_D        = ($urandom_range(0, 2) != 0);
      wd_D        = AW'($urandom_range(0, 7));
      lat_D       = LW'($urandom_range(0, 7));
      freeze      = ($urandom_range(0, 5) == 0);
      flush_D     = ($urandom_range(0, 7) == 0);
      #1;
      m_stall = issue_valid && !flush_D && ((re1_D && m_busy(rs_D)) || (re2_D && m_busy(rt_D)));
      for (int r = 0; r < NR; r++) m_busy_vec[r] = m_busy(AW'(r));
      if (model_valid) begin
        check("rnd_stall", c, NR'(stall), NR'(m_stall));
        check("rnd_busy", c, busy, m_busy_vec);
        check("rnd_stall_cycles", c, NR'(stall_cycles), NR'(msc));
      end
      @(posedge clk);
      if (!rst_n) begin
        for (int r = 0; r < NR; r++) ready_at[r] = 0;
        active = 0;
        msc = 0;
        model_valid = 1'b1;
      end else if (!freeze) begin
        if (m_stall) msc = (msc == SC_MAX) ? SC_MAX : msc + 1;
        if (issue_valid && !m_stall && !flush_D && we_D && wd_D != 0)
          ready_at[wd_D] = active + 1 + int'(lat_D);
        active++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
